// File: rtl/tarb_pkg.sv
// Shared types for the traversal arbiter: ray payload, source indices and the
// fixed-priority pick (highest source index wins).
package tarb_pkg;

    typedef struct packed {
        logic [15:0] ray_id;
        logic [31:0] t_min;
        logic [31:0] t_max;
    } tarb_t;

    localparam int TARB_NUM_SRC = 3;

    typedef enum logic [1:0] {
        SRC_SINT,
        SRC_SS,
        SRC_TRAV
    } tarb_src_e;

    // One-hot grant: reissued rays first, then short-stack restarts, then new rays.
    function automatic logic [TARB_NUM_SRC-1:0] prio_pick(input logic [TARB_NUM_SRC-1:0] req);
        logic [TARB_NUM_SRC-1:0] g;
        g = '0;
        if (req[SRC_TRAV])      g[SRC_TRAV] = 1'b1;
        else if (req[SRC_SS])   g[SRC_SS]   = 1'b1;
        else if (req[SRC_SINT]) g[SRC_SINT] = 1'b1;
        return g;
    endfunction

endpackage

// File: rtl/tarb_skid.sv
// Output register O plus one skid register K. Acceptance depends only on K,
// so upstream stall never sees the downstream stall combinationally.
module tarb_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    output logic         o_acc,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    input  logic         i_stall
);

    logic         r_o_valid;
    logic [W-1:0] r_o_data;
    logic         r_k_valid;
    logic [W-1:0] r_k_data;
    logic         w_push;
    logic         w_drain;

    assign o_acc   = ~r_k_valid;
    assign w_push  = i_valid & ~r_k_valid;
    assign w_drain = r_o_valid & ~i_stall;
    assign o_valid = r_o_valid;
    assign o_data  = r_o_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_o_valid <= 1'b0;
            r_o_data  <= '0;
            r_k_valid <= 1'b0;
            r_k_data  <= '0;
        end else if (w_drain | ~r_o_valid) begin
            // O is free this cycle: K refills it first, otherwise the new ray does
            if (r_k_valid) begin
                r_o_valid <= 1'b1;
                r_o_data  <= r_k_data;
                r_k_valid <= 1'b0;
            end else begin
                r_o_valid <= w_push;
                if (w_push) r_o_data <= i_data;
            end
        end else if (w_push) begin
            r_k_valid <= 1'b1;
            r_k_data  <= i_data;
        end
    end

endmodule

// File: rtl/tarb.sv
// Traversal arbiter: merges sint/ss/trav ray streams with a credit limit on new
// rays. Define TARB_FAIR_EN to add per-source starvation counters.
module tarb
    import tarb_pkg::*;
#(
    parameter int MAX_INFLIGHT = 64,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              sint_to_tarb_valid,
    input  tarb_t                             sint_to_tarb_data,
    output logic                              sint_to_tarb_stall,
    input  logic                              ss_to_tarb_valid,
    input  tarb_t                             ss_to_tarb_data,
    output logic                              ss_to_tarb_stall,
    input  logic                              trav_to_tarb_valid,
    input  tarb_t                             trav_to_tarb_data,
    output logic                              trav_to_tarb_stall,
    output logic                              tarb_to_trav_valid,
    output tarb_t                             tarb_to_trav_data,
    input  logic                              tarb_to_trav_stall,
    input  logic                              ray_retire,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight_cnt
);

    localparam int CW = $clog2(MAX_INFLIGHT+1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_INFLIGHT);

    logic [CW-1:0]           r_cnt;
    logic [TARB_NUM_SRC-1:0] w_valid;
    logic [TARB_NUM_SRC-1:0] w_elig;
    logic [TARB_NUM_SRC-1:0] w_grant;
    logic                    w_skid_acc;
    logic                    w_acc;
    logic                    w_inc;
    tarb_t                   w_data;

    assign w_valid = {trav_to_tarb_valid, ss_to_tarb_valid, sint_to_tarb_valid};
    assign w_elig  = w_valid & {2'b11, (r_cnt < MAX_C)};
    assign w_acc   = w_skid_acc & ~rst;

`ifdef TARB_FAIR_EN
    localparam int WW = $clog2(STARVE_LIMIT+1);
    localparam logic [WW-1:0] LIM = WW'(STARVE_LIMIT);

    logic [TARB_NUM_SRC-1:0][WW-1:0] r_wait;
    logic [TARB_NUM_SRC-1:0]         w_starved;

    always_comb begin
        w_starved = '0;
        for (int i = 0; i < TARB_NUM_SRC; i++)
            w_starved[i] = w_elig[i] & (r_wait[i] == LIM);
    end

    // Starved sources preempt; fixed priority still orders them among themselves
    assign w_grant = (|w_starved) ? prio_pick(w_starved) : prio_pick(w_elig);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait <= '0;
        end else begin
            for (int i = 0; i < TARB_NUM_SRC; i++) begin
                if (~w_valid[i] | (w_acc & w_grant[i]))
                    r_wait[i] <= '0;
                else if (w_elig[i] & w_acc & (r_wait[i] != LIM))
                    r_wait[i] <= r_wait[i] + 1'b1;
            end
        end
    end
`else
    // Starvation limit has no effect in the fixed-priority build
    localparam int unused_starve_limit = STARVE_LIMIT;

    assign w_grant = prio_pick(w_elig);
`endif

    always_comb begin
        w_data = '0;
        if (w_grant[SRC_TRAV])      w_data = trav_to_tarb_data;
        else if (w_grant[SRC_SS])   w_data = ss_to_tarb_data;
        else if (w_grant[SRC_SINT]) w_data = sint_to_tarb_data;
    end

    assign sint_to_tarb_stall = sint_to_tarb_valid & ~(w_acc & w_grant[SRC_SINT]);
    assign ss_to_tarb_stall   = ss_to_tarb_valid   & ~(w_acc & w_grant[SRC_SS]);
    assign trav_to_tarb_stall = trav_to_tarb_valid & ~(w_acc & w_grant[SRC_TRAV]);

    tarb_skid #(.W($bits(tarb_t))) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_valid (|w_grant),
        .i_data  (w_data),
        .o_acc   (w_skid_acc),
        .o_valid (tarb_to_trav_valid),
        .o_data  (tarb_to_trav_data),
        .i_stall (tarb_to_trav_stall)
    );

    assign w_inc = w_acc & w_grant[SRC_SINT];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_inc & ~ray_retire) begin
            if (r_cnt != MAX_C) r_cnt <= r_cnt + 1'b1;
        end else if (~w_inc & ray_retire) begin
            if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
    end

`ifndef SYNTH
    always_ff @(posedge clk) begin
        if (!rst && ray_retire && !w_inc && r_cnt == '0)
            $error("tarb: ray_retire with no new rays in flight");
    end
`endif

    assign inflight_cnt = r_cnt;

endmodule

// File: doc/tarb.md
# tarb

Traversal arbiter: merges the three ray streams that enter kd-tree traversal into one registered stream for the traversal pipeline. Sources:
- `sint_to_tarb`: new rays from scene intersection.
- `ss_to_tarb`: restarts from short-stack pops.
- `trav_to_tarb`: rays reissued by traversal/list stages.

It sits directly downstream of scene intersection. It limits how many new rays circulate in the traversal loop so in-flight rays can always make progress.

## Interface
Parameters:
- `MAX_INFLIGHT`, 64: maximum new rays admitted and not yet retired.
- `STARVE_LIMIT`, 16: wait cycles before a starved source is forced to win (used only with `TARB_FAIR_EN`).

Ports (clock and reset first):
- `clk`  in  1  Single clock.
- `rst`  in  1  Synchronous, active-high reset.
- `sint_to_tarb_valid` / `sint_to_tarb_data` / `sint_to_tarb_stall`  in / in / out  1 / `$bits(tarb_t)` / 1  New rays (source 0).
- `ss_to_tarb_valid` / `ss_to_tarb_data` / `ss_to_tarb_stall`  in / in / out  1 / `$bits(tarb_t)` / 1  Short-stack restarts (source 1).
- `trav_to_tarb_valid` / `trav_to_tarb_data` / `trav_to_tarb_stall`  in / in / out  1 / `$bits(tarb_t)` / 1  Reissued rays (source 2).
- `tarb_to_trav_valid`  out  1  Output valid.
- `tarb_to_trav_data`  out  `$bits(tarb_t)`  Output ray.
- `tarb_to_trav_stall`  in  1  Downstream stall.
- `ray_retire`  in  1  One-cycle pulse per ray leaving the loop (hit or miss delivered to the shader).
- `inflight_cnt`  out  `$clog2(MAX_INFLIGHT+1)`  Current count of new rays in flight.

## Operation
- **Handshake:** a transfer occurs when valid is high and stall is low. A source holds valid and data stable while stalled. `tarb_t` passes through bit-exact.
- **Storage:** output register `O` plus one skid register `K`.
- **Acceptance:** `acc = ~K.valid`. When `acc` is high, one valid, eligible source is granted.
  - `stall_i = valid_i & ~(acc & grant_i)`.
  - The stall outputs depend only on registered state and the input valids. They never depend combinationally on `tarb_to_trav_stall`.
- **Priority:** fixed, source 2 > source 1 > source 0.
- **Eligibility of source 0:** eligible only if `inflight_cnt < MAX_INFLIGHT`.
- **Placement of a granted ray:**
  - Into `O` if `O` is empty, or if `O` drains this cycle and `K` is empty.
  - Otherwise into `K`.
- **Draining:** when `O` drains and `K` is valid, `K` moves to `O`.
- **Credit counter:**
  - Incremented when source 0 is granted.
  - Decremented when `ray_retire` is high.
  - Unchanged when both happen in the same cycle.
  - Saturates at 0 and at `MAX_INFLIGHT`.
  - A retire while the count is 0 fires an `$error` in non-SYNTH builds and leaves the count at 0.
- **Reset:**
  - `tarb_to_trav_valid` = 0, `tarb_to_trav_data` = 0.
  - `K` is empty.
  - `inflight_cnt` = 0.
  - Wait counters are 0.
  - While `rst` is high, every stall output equals its source's valid (nothing is accepted).
  - A reset asserted mid-operation discards `O` and `K` contents in the same cycle.

## Timing
- **Latency:** 1 cycle from acceptance to `tarb_to_trav_valid` when `O` is empty. 2 cycles when the ray goes through `K`.
- **Throughput:** 1 ray per cycle while downstream does not stall.
- **Downstream stall:**
  - Cycle 1 of a stall: `K` can still absorb one ray.
  - From the next cycle: all sources are stalled until `O` drains.
  - First cycle after the stall releases: `O` drains and `K` moves into `O`, so nothing is accepted.
  - From the following cycle: acceptance resumes.
- **Same-cycle events:** grant, drain, and retire in one cycle are all honoured in that cycle.

## Configuration
Macro: `TARB_FAIR_EN`.

With `TARB_FAIR_EN` defined:
- Each source has a wait counter of width `$clog2(STARVE_LIMIT+1)`.
- The counter increments in each cycle the source is valid, eligible, and stalled while `acc` is high.
- The counter clears on the source's grant, and when the source is not valid.
- A source whose counter equals `STARVE_LIMIT` overrides fixed priority. If several sources are starved, fixed priority applies among them.
- Source 0 is never forced while it is credit-ineligible.

Without `TARB_FAIR_EN`:
- Strict fixed priority.
- No wait counters are instantiated; the `STARVE_LIMIT` parameter is ignored.

## Structure
- Shared package (`tarb_t` and its fields are already there): add
  - `TARB_NUM_SRC` = 3;
  - enum `tarb_src_e` {`SRC_SINT`, `SRC_SS`, `SRC_TRAV`}.
- One sub-module: `tarb_skid`. It holds the `O`/`K` register pair: parameterised width, valid/stall in and out, and the `acc` output.
- Grant logic and the credit counter live in `tarb`.

## Test plan
- **Single ray:** `sint` sends one ray (rayID 5, t_min 0, t_max 1.0) with downstream idle.
  - Output is bit-identical one cycle later.
  - `inflight_cnt` = 1.
- **All sources valid for 3 cycles, no stall:**
  - Grants are trav, trav, trav.
  - `ss_to_tarb_stall` and `sint_to_tarb_stall` stay high.
  - With `TARB_FAIR_EN` and `STARVE_LIMIT` = 2, the grants become trav, trav, ss.
- **Downstream stall for 4 cycles during a stream from `ss`:**
  - Exactly one ray is absorbed into `K`.
  - No ray is lost or duplicated.
  - Output order is preserved after release.
- **`MAX_INFLIGHT` = 2, sint streaming 3 rays:**
  - The third ray stalls.
  - A `ray_retire` pulse lets it through the next cycle.
  - Grant and retire in the same cycle keep the count at 2.
- **`rst` asserted while `O` and `K` are both full:**
  - Next cycle: `tarb_to_trav_valid` = 0 and `inflight_cnt` = 0.
  - The first ray offered after reset appears with 1-cycle latency.
